sorted_insert_buf: RTL and testbench

SORTED_INSERT_BUF -- requirements
Module: sorted_insert_buf

---
 rtl/sorted_insert_buf.sv | 193 +++++++++++++++++++
 tb/tb_sorted_insert_buf.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sorted_insert_buf.sv
`default_nettype none
// ============================================================================
// Module      : sorted_insert_buf
// Description : Collects one row of (key, data) entries into a buffer kept in
//               ascending key order. Entries with equal keys are summed. At
//               the end of the row the buffer drains in ascending key order.
// Revision    : 1.0 - initial release
// ============================================================================
module sorted_insert_buf #(
    parameter int data_width_param = 32,
    parameter int idx_width_param  = 4,
    parameter int depth_param      = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [idx_width_param-1:0]    in_key,
    input  logic [data_width_param-1:0]   in_data,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [idx_width_param-1:0]    out_key,
    output logic [data_width_param-1:0]   out_data,
    output logic                          out_last,
    output logic [$clog2(depth_param):0]  count,
    output logic                          overflow
);

    localparam int              c_cw    = $clog2(depth_param) + 1;
    localparam logic [c_cw-1:0] c_depth = c_cw'(depth_param);
    localparam logic [c_cw-1:0] c_one   = c_cw'(1);

    typedef enum logic [1:0] {
        S_FILL   = 2'd0,
        S_INSERT = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [idx_width_param-1:0]  r_key  [depth_param];
    logic [data_width_param-1:0] r_data [depth_param];
    logic [c_cw-1:0]             r_count;
    logic                        r_overflow;

    logic [idx_width_param-1:0]  r_stage_key;
    logic [data_width_param-1:0] r_stage_data;
    logic                        r_stage_last;

    logic [c_cw-1:0] w_pos;
    logic            w_hit;
    logic            w_full;
    logic [c_cw-1:0] w_count_ins;
    logic            w_accept;
    logic            w_drain_hs;

    // Slots are sorted, so the insertion point is the count of smaller keys.
    always_comb begin
        w_pos = '0;
        w_hit = 1'b0;
        for (int i = 0; i < depth_param; i++) begin
            if (c_cw'(i) < r_count && r_key[i] < r_stage_key) begin
                w_pos = w_pos + c_one;
            end
        end
        for (int i = 0; i < depth_param; i++) begin
            if (c_cw'(i) == w_pos && c_cw'(i) < r_count && r_key[i] == r_stage_key) begin
                w_hit = 1'b1;
            end
        end
    end

    assign w_full      = (r_count == c_depth);
    assign w_count_ins = (w_hit || w_full) ? r_count : r_count + c_one;
    assign w_accept    = (r_state == S_FILL) && in_valid;
    assign w_drain_hs  = (r_state == S_DRAIN) && out_ready;

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_key     = '0;
        out_data    = '0;
        out_last    = 1'b0;
        case (r_state)
            S_FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_INSERT;
                end
            end
            S_INSERT: begin
                if (r_stage_last && (w_count_ins != '0)) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_state_nxt = S_FILL;
                end
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                out_key   = r_key[0];
                out_data  = r_data[0];
                out_last  = (r_count == c_one);
                if (out_ready && (r_count == c_one)) begin
                    w_state_nxt = S_FILL;
                end
            end
            default: begin
                w_state_nxt = S_FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage_key  <= '0;
            r_stage_data <= '0;
            r_stage_last <= 1'b0;
        end else if (w_accept) begin
            r_stage_key  <= in_key;
            r_stage_data <= in_data;
            r_stage_last <= in_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (r_state == S_INSERT) begin
            r_count <= w_count_ins;
            if (!w_hit && w_full) begin
                r_overflow <= 1'b1;
            end
        end else if (w_drain_hs) begin
            r_count <= r_count - c_one;
            if (r_count == c_one) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < depth_param; i++) begin
                r_key[i]  <= '0;
                r_data[i] <= '0;
            end
        end else if (r_state == S_INSERT) begin
            if (w_hit) begin
                for (int i = 0; i < depth_param; i++) begin
                    if (c_cw'(i) == w_pos) begin
                        r_data[i] <= r_data[i] + r_stage_data;
                    end
                end
            end else if (!w_full) begin
                for (int i = 0; i < depth_param; i++) begin
                    if (c_cw'(i) == w_pos) begin
                        r_key[i]  <= r_stage_key;
                        r_data[i] <= r_stage_data;
                    end
                end
                // Open a hole at pos by moving the larger keys up one slot.
                for (int i = 1; i < depth_param; i++) begin
                    if (c_cw'(i) > w_pos && c_cw'(i) <= r_count) begin
                        r_key[i]  <= r_key[i-1];
                        r_data[i] <= r_data[i-1];
                    end
                end
            end
        end else if (w_drain_hs) begin
            for (int i = 0; i < depth_param - 1; i++) begin
                r_key[i]  <= r_key[i+1];
                r_data[i] <= r_data[i+1];
            end
        end
    end

    assign count    = r_count;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_sorted_insert_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_sorted_insert_buf
// Description : Scoreboard bench for sorted_insert_buf with directed rows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sorted_insert_buf;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_key;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_key;
    logic [31:0] out_data;
    logic        out_last;
    logic [3:0]  count;
    logic        overflow;

    typedef struct packed {
        logic [3:0]  key;
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    sorted_insert_buf #(
        .data_width_param (32),
        .idx_width_param  (4),
        .depth_param      (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_key    (in_key),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_key   (out_key),
        .out_data  (out_data),
        .out_last  (out_last),
        .count     (count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted drain beat is compared with the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", {28'd0, out_key, out_data}, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("drain_key",  64'(out_key),  64'(e.key));
                chk("drain_data", 64'(out_data), 64'(e.data));
                chk("drain_last", 64'(out_last), 64'(e.last));
            end
        end
    end

    task automatic expect_beat(input logic [3:0] k, input logic [31:0] d, input logic l);
        exp_t e;
        e.key  = k;
        e.data = d;
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [3:0] k, input logic [31:0] d, input logic l);
        int t;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_key   = k;
        in_data  = d;
        in_last  = l;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 100) begin
                chk("send_timeout", 64'd1, 64'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int t;
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("wait_out_valid", 64'(out_valid), 64'd1);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (!(exp_q.size() == 0 && !out_valid && count == 4'd0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
        chk("count_after_drain", 64'(count), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_key    = '0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_count",     64'(count),     64'd0);
        chk("rst_overflow",  64'(overflow),  64'd0);
        chk("rst_out_key",   64'(out_key),   64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_out_last",  64'(out_last),  64'd0);
        rst_n = 1'b1;

        // Basic ordering
        expect_beat(4'd2, 32'd20, 1'b0);
        expect_beat(4'd5, 32'd50, 1'b0);
        expect_beat(4'd9, 32'd90, 1'b1);
        send(4'd5, 32'd50, 1'b0);
        send(4'd2, 32'd20, 1'b0);
        send(4'd9, 32'd90, 1'b1);
        wait_drain();

        // Duplicate keys accumulate
        expect_beat(4'd3, 32'd15, 1'b0);
        expect_beat(4'd7, 32'd1,  1'b1);
        send(4'd3, 32'd10, 1'b0);
        send(4'd7, 32'd1,  1'b0);
        send(4'd3, 32'd5,  1'b1);
        wait_drain();

        // Full buffer: the ninth distinct key is dropped
        for (int k = 0; k < 8; k++) begin
            expect_beat(4'(k), 32'(100 + k), (k == 7));
        end
        for (int k = 0; k < 8; k++) begin
            send(4'(k), 32'(100 + k), 1'b0);
        end
        send(4'd12, 32'd999, 1'b1);
        wait_valid();
        chk("overflow_in_drain", 64'(overflow), 64'd1);
        wait_drain();
        chk("overflow_cleared", 64'(overflow), 64'd0);

        // Backpressure: outputs hold while out_ready is low
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        expect_beat(4'd2, 32'd20, 1'b0);
        expect_beat(4'd5, 32'd50, 1'b0);
        expect_beat(4'd9, 32'd90, 1'b1);
        send(4'd5, 32'd50, 1'b0);
        send(4'd2, 32'd20, 1'b0);
        send(4'd9, 32'd90, 1'b1);
        wait_valid();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_key",   64'(out_key),   64'd2);
            chk("hold_data",  64'(out_data),  64'd20);
            chk("hold_count", 64'(count),     64'd3);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain();

        // Reset in the middle of a drain
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(4'd1, 32'd11, 1'b0);
        send(4'd2, 32'd22, 1'b0);
        send(4'd3, 32'd33, 1'b1);
        wait_valid();
        chk("pre_rst_count", 64'(count), 64'd3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_count",     64'(count),     64'd0);
        chk("mid_rst_in_ready",  64'(in_ready),  64'd1);
        chk("mid_rst_out_key",   64'(out_key),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        expect_beat(4'd1, 32'd77, 1'b1);
        send(4'd1, 32'd77, 1'b1);
        wait_drain();

        // Accumulation wraps modulo 2^32
        expect_beat(4'd4, 32'h0000_0001, 1'b1);
        send(4'd4, 32'hFFFF_FFFF, 1'b0);
        send(4'd4, 32'd2, 1'b1);
        wait_drain();

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
